// File: rtl/med_reminder_pkg.sv
// Shared state encoding and width defaults for the medicine reminder scheduler.
package med_reminder_pkg;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_SET   = 2'd1,
    S_ALARM = 2'd2
  } state_e;

  localparam int MIN_W_DFLT    = 8;
  localparam int MISSED_W_DFLT = 4;

endpackage

// File: rtl/med_reminder_min_timebase.sv
// Seconds prescaler: turns Tick_1s pulses into a one-cycle minute strobe.
// Clear forces the second count back to zero and suppresses the strobe.
module min_timebase #(
  parameter int SEC_PER_MIN = 60
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Tick_1s,
  input  logic clr,
  output logic min_tick
);

  localparam int SEC_W = (SEC_PER_MIN > 1) ? $clog2(SEC_PER_MIN) : 1;
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_PER_MIN - 1);
  localparam logic [SEC_W-1:0] SEC_ONE  = SEC_W'(1);

  logic [SEC_W-1:0] sec_cnt_q, sec_cnt_d;

  // Strobe on the last second of each minute; a clear takes priority.
  always_comb begin
    min_tick  = Tick_1s && !clr && (sec_cnt_q == SEC_LAST);
    sec_cnt_d = sec_cnt_q;
    if (clr)           sec_cnt_d = '0;
    else if (min_tick) sec_cnt_d = '0;
    else if (Tick_1s)  sec_cnt_d = sec_cnt_q + SEC_ONE;
  end

  // Second counter register.
  always_ff @(posedge Clk) begin
    if (!Rst) sec_cnt_q <= '0;
    else      sec_cnt_q <= sec_cnt_d;
  end

endmodule

// File: rtl/med_reminder_ctrl.sv
// Dose-reminder scheduler: counts down a programmable interval in minutes,
// raises Alarm at expiry, handles acknowledge, alarm timeout (missed dose)
// and interval programming.
// Optional feature macro: SNOOZE_EN (BtnInc in alarm snoozes for SNOOZE_MIN).
module med_reminder_ctrl
  import med_reminder_pkg::*;
#(
  parameter int MIN_W            = MIN_W_DFLT,
  parameter int MISSED_W         = MISSED_W_DFLT,
  parameter int SEC_PER_MIN      = 60,
  parameter int DEFAULT_INTERVAL = 240,
  parameter int ALARM_TIMEOUT    = 30,
  parameter int SNOOZE_MIN       = 5
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Tick_1s,
  input  logic                BtnMode,
  input  logic                BtnInc,
  input  logic                BtnAck,
  output logic                Alarm,
  output logic                SetMode,
  output logic [MIN_W-1:0]    Interval,
  output logic [MIN_W-1:0]    Countdown,
  output logic [MISSED_W-1:0] MissedCount,
  output logic [1:0]          State
);

  localparam logic [MIN_W-1:0]    ONE_MIN     = MIN_W'(1);
  localparam logic [MIN_W-1:0]    DFLT_IV     = MIN_W'(DEFAULT_INTERVAL);
  localparam logic [MIN_W-1:0]    TIMEOUT_M1  = MIN_W'(ALARM_TIMEOUT - 1);
  localparam logic [MISSED_W-1:0] MISSED_ONE  = MISSED_W'(1);

  state_e                state_q, state_d;
  logic [MIN_W-1:0]      interval_q, interval_d;
  logic [MIN_W-1:0]      countdown_q, countdown_d;
  logic [MIN_W-1:0]      alarm_min_q, alarm_min_d;
  logic [MISSED_W-1:0]   missed_q, missed_d;
  logic                  alarm_q, alarm_d;
  logic                  setmode_q, setmode_d;
  logic                  sec_clr;
  logic                  min_tick;
  logic                  snooze;

`ifdef SNOOZE_EN
  localparam logic [MIN_W-1:0] SNOOZE_CD = MIN_W'(SNOOZE_MIN);
  assign snooze = BtnInc;
`else
  // Snooze length only matters when snoozing is built in.
  logic unused_snooze;
  assign unused_snooze = ^MIN_W'(SNOOZE_MIN);
  assign snooze = 1'b0;
`endif

  // Second count is restarted whenever the minute phase must realign:
  // throughout set mode, on entering it, on leaving an alarm by button,
  // and on recovery from an illegal state.
  always_comb begin
    sec_clr = 1'b0;
    case (state_q)
      S_RUN:   sec_clr = BtnMode;
      S_SET:   sec_clr = 1'b1;
      S_ALARM: sec_clr = BtnAck | snooze;
      default: sec_clr = 1'b1;
    endcase
  end

  min_timebase #(
    .SEC_PER_MIN (SEC_PER_MIN)
  ) u_timebase (
    .Clk      (Clk),
    .Rst      (Rst),
    .Tick_1s  (Tick_1s),
    .clr      (sec_clr),
    .min_tick (min_tick)
  );

  // Next-state and datapath: one priority chain per state.
  always_comb begin
    state_d     = state_q;
    interval_d  = interval_q;
    countdown_d = countdown_q;
    alarm_min_d = alarm_min_q;
    missed_d    = missed_q;
    case (state_q)
      S_RUN: begin
        if (BtnMode) begin
          state_d = S_SET;
        end else if (min_tick) begin
          if (countdown_q <= ONE_MIN) begin
            countdown_d = '0;
            alarm_min_d = '0;
            state_d     = S_ALARM;
          end else begin
            countdown_d = countdown_q - ONE_MIN;
          end
        end
      end
      S_SET: begin
        if (BtnMode) begin
          state_d     = S_RUN;
          countdown_d = interval_q;
        end else if (BtnInc) begin
          // Interval never becomes 0: all-ones wraps to 1.
          interval_d = (&interval_q) ? ONE_MIN : interval_q + ONE_MIN;
        end
      end
      S_ALARM: begin
        if (BtnAck) begin
          state_d     = S_RUN;
          countdown_d = interval_q;
`ifdef SNOOZE_EN
        end else if (BtnInc) begin
          state_d     = S_RUN;
          countdown_d = SNOOZE_CD;
`endif
        end else if (min_tick) begin
          alarm_min_d = alarm_min_q + ONE_MIN;
          if (alarm_min_q >= TIMEOUT_M1) begin
            state_d     = S_RUN;
            countdown_d = interval_q;
            missed_d    = (&missed_q) ? missed_q : missed_q + MISSED_ONE;
          end
        end
      end
      default: begin
        state_d     = S_RUN;
        countdown_d = interval_q;
      end
    endcase
    alarm_d   = (state_d == S_ALARM);
    setmode_d = (state_d == S_SET);
  end

  // State and datapath registers.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q     <= S_RUN;
      interval_q  <= DFLT_IV;
      countdown_q <= DFLT_IV;
      alarm_min_q <= '0;
      missed_q    <= '0;
      alarm_q     <= 1'b0;
      setmode_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      interval_q  <= interval_d;
      countdown_q <= countdown_d;
      alarm_min_q <= alarm_min_d;
      missed_q    <= missed_d;
      alarm_q     <= alarm_d;
      setmode_q   <= setmode_d;
    end
  end

  assign Alarm       = alarm_q;
  assign SetMode     = setmode_q;
  assign Interval    = interval_q;
  assign Countdown   = countdown_q;
  assign MissedCount = missed_q;
  assign State       = state_q;

endmodule

// File: tb/tb_med_reminder_ctrl.sv
// Scoreboard bench for med_reminder_ctrl (SEC_PER_MIN=2, DEFAULT_INTERVAL=3,
// ALARM_TIMEOUT=2, SNOOZE_MIN=5). Stimulus pushes hand-derived snapshots;
// a negedge monitor pops and compares them.
module tb_med_reminder_ctrl;

  localparam int MIN_W    = 8;
  localparam int MISSED_W = 4;
  localparam logic [1:0] RUN = 2'd0, SET = 2'd1, ALM = 2'd2;

  typedef struct {
    string                name;
    logic [1:0]           st;
    logic [MIN_W-1:0]     cd;
    logic [MIN_W-1:0]     iv;
    logic [MISSED_W-1:0]  ms;
  } exp_t;

  logic                Clk = 1'b0;
  logic                Rst = 1'b0;
  logic                Tick_1s = 1'b0, BtnMode = 1'b0, BtnInc = 1'b0, BtnAck = 1'b0;
  logic                Alarm, SetMode;
  logic [MIN_W-1:0]    Interval, Countdown;
  logic [MISSED_W-1:0] MissedCount;
  logic [1:0]          State;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t sb[$];

  // expected values maintained by the directed sequence
  logic [1:0]          e_st;
  logic [MIN_W-1:0]    e_cd, e_iv;
  logic [MISSED_W-1:0] e_ms;

  med_reminder_ctrl #(
    .MIN_W(MIN_W), .MISSED_W(MISSED_W), .SEC_PER_MIN(2),
    .DEFAULT_INTERVAL(3), .ALARM_TIMEOUT(2), .SNOOZE_MIN(5)
  ) dut (
    .Clk(Clk), .Rst(Rst), .Tick_1s(Tick_1s), .BtnMode(BtnMode),
    .BtnInc(BtnInc), .BtnAck(BtnAck), .Alarm(Alarm), .SetMode(SetMode),
    .Interval(Interval), .Countdown(Countdown), .MissedCount(MissedCount),
    .State(State)
  );

  always #5 Clk = ~Clk;

  // monitor: one snapshot compared per cycle while expectations are pending
  always @(negedge Clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (State !== e.st || Countdown !== e.cd || Interval !== e.iv ||
          MissedCount !== e.ms || Alarm !== (e.st == ALM) || SetMode !== (e.st == SET)) begin
        n_bad++;
        $display("FAIL %s: got st=%0d cd=%0d iv=%0d ms=%0d al=%0b sm=%0b want st=%0d cd=%0d iv=%0d ms=%0d al=%0b sm=%0b",
                 e.name, State, Countdown, Interval, MissedCount, Alarm, SetMode,
                 e.st, e.cd, e.iv, e.ms, (e.st == ALM), (e.st == SET));
      end
    end
  end

  task automatic push(input string nm);
    exp_t e;
    e.name = nm; e.st = e_st; e.cd = e_cd; e.iv = e_iv; e.ms = e_ms;
    sb.push_back(e);
  endtask

  // one clock with the given pulses, then queue the expected post-edge snapshot
  task automatic step(input logic r, input logic t, input logic m, input logic i,
                      input logic a, input string nm);
    @(negedge Clk);
    Rst = r; Tick_1s = t; BtnMode = m; BtnInc = i; BtnAck = a;
    @(posedge Clk);
    #1;
    Tick_1s = 0; BtnMode = 0; BtnInc = 0; BtnAck = 0;
    push(nm);
  endtask

  task automatic tick(input string nm);
    step(1, 1, 0, 0, 0, nm);
  endtask

  initial begin
    // reset
    e_st = RUN; e_cd = 3; e_iv = 3; e_ms = 0;
    step(0, 1, 1, 1, 1, "reset0");
    step(0, 0, 0, 0, 0, "reset1");

    // countdown 3,2,1,0 on ticks 2/4/6, alarm after tick 6
    for (int k = 1; k <= 6; k++) begin
      if (k % 2 == 0) e_cd = MIN_W'(3 - k / 2);
      if (k == 6) e_st = ALM;
      tick($sformatf("cd_tick%0d", k));
    end
    e_st = RUN; e_cd = 3;
    step(1, 0, 0, 0, 1, "ack");

    // back to alarm, BtnMode ignored there, then timeout after 4 ticks
    for (int k = 1; k <= 6; k++) begin
      if (k % 2 == 0) e_cd = MIN_W'(3 - k / 2);
      if (k == 6) e_st = ALM;
      tick($sformatf("cd2_tick%0d", k));
    end
    step(1, 0, 1, 0, 0, "alarm_mode_ignored");
`ifndef SNOOZE_EN
    step(1, 0, 0, 1, 0, "alarm_inc_ignored");
`endif
    tick("to_t1"); tick("to_t2"); tick("to_t3");
    e_st = RUN; e_cd = 3; e_ms = 1;
    tick("timeout_miss");

    // inc/ack ignored while running
    step(1, 0, 0, 1, 1, "run_btn_ignored");

    // set mode: 253 increments wrap 255 -> 1
    e_st = SET;
    step(1, 0, 1, 0, 0, "enter_set");
    for (int k = 1; k <= 253; k++) begin
      e_iv = (e_iv == 8'd255) ? 8'd1 : e_iv + 8'd1;
      step(1, 0, 0, 1, 0, $sformatf("inc%0d", k));
    end
    step(1, 0, 0, 0, 1, "set_ack_ignored");
    tick("set_tick_frozen"); tick("set_tick_frozen2");
    e_st = RUN; e_cd = 1;
    step(1, 0, 1, 0, 0, "leave_set");

    // mode+inc together: mode wins, interval unchanged
    e_st = SET;
    step(1, 0, 1, 0, 0, "enter_set2");
    e_st = RUN;
    step(1, 0, 1, 1, 0, "mode_beats_inc");

    // mode beats a same-cycle minute tick
    tick("half_min");
    e_st = SET;
    step(1, 1, 1, 0, 0, "mode_beats_tick");
    e_st = RUN;
    step(1, 0, 1, 0, 0, "leave_set3");

    // ack beats timeout in the same cycle
    tick("a_t1");
    e_st = ALM; e_cd = 0;
    tick("a_t2");
    tick("a_t3"); tick("a_t4"); tick("a_t5");
    e_st = RUN; e_cd = 1;
    step(1, 1, 0, 0, 1, "ack_beats_timeout");

    // snooze (or its absence)
    tick("s_t1");
    e_st = ALM; e_cd = 0;
    tick("s_t2");
`ifdef SNOOZE_EN
    e_st = RUN; e_cd = 5;
    step(1, 0, 0, 1, 0, "snooze");
    e_st = SET;
    step(1, 0, 1, 0, 0, "s_set");
    e_st = RUN; e_cd = 1;
    step(1, 0, 1, 0, 0, "s_run");
`else
    step(1, 0, 0, 1, 0, "no_snooze");
    e_st = RUN; e_cd = 1;
    step(1, 0, 0, 0, 1, "s_ack");
`endif

    // repeated misses saturate the counter at 15
    for (int r = 0; r < 15; r++) begin
      tick("m_t1");
      e_st = ALM; e_cd = 0;
      tick("m_t2"); tick("m_t3"); tick("m_t4"); tick("m_t5");
      e_st = RUN; e_cd = 1;
      e_ms = (e_ms == 4'hF) ? 4'hF : e_ms + 4'd1;
      tick($sformatf("miss_%0d", r));
    end

    // drain the scoreboard with a bounded wait
    for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge Clk);
    if (sb.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time expired, required completion");
    $fatal(1);
  end

endmodule
